// File: rtl/output_pixel_streamer_pkg.sv
// Shared constants and FSM encoding for the output pixel streamer.
// Imported by the interface, the prefetch buffer and the top level.
package output_pixel_streamer_pkg;

    localparam int AddressSize   = 16;
    localparam int DataBusSize   = 128;
    localparam int PixelWidth    = 8;
    localparam int PixelsPerWord = 16;
    localparam int IndexWidth    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/output_pixel_streamer_if.sv
// Pixel stream handshake: data/valid/last forward, ready backward.
// master = streamer side, slave = consumer side.
interface output_pixel_streamer_if;
    import output_pixel_streamer_pkg::*;

    logic [PixelWidth-1:0] PixelData;
    logic                  PixelValid;
    logic                  PixelReady;
    logic                  PixelLast;

    modport master (
        output PixelData,
        output PixelValid,
        output PixelLast,
        input  PixelReady
    );

    modport slave (
        input  PixelData,
        input  PixelValid,
        input  PixelLast,
        output PixelReady
    );

endinterface

// File: rtl/output_pixel_streamer_word_prefetch_buffer.sv
// Two-word (CUR/NXT) prefetch buffer serializing 128-bit words MSB-first.
// Ports: clk_i, rst_ni (sync, low), issue_i, rdata_i, ready_i,
//        pix_o, valid_o, can_issue_o.
module word_prefetch_buffer
    import output_pixel_streamer_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   issue_i,
    input  logic [DataBusSize-1:0] rdata_i,
    input  logic                   ready_i,
    output logic [PixelWidth-1:0]  pix_o,
    output logic                   valid_o,
    output logic                   can_issue_o
);

    logic [DataBusSize-1:0] cur_q, cur_d;
    logic [DataBusSize-1:0] nxt_q, nxt_d;
    logic                   cur_v_q, cur_v_d;
    logic                   nxt_v_q, nxt_v_d;
    logic                   pend_q, pend_d;
    logic [IndexWidth-1:0]  idx_q, idx_d;
    logic                   xfer;
    logic                   vacate;
    logic [DataBusSize-1:0] shifted;

    assign xfer   = cur_v_q && ready_i;
    assign vacate = xfer && (idx_q == IndexWidth'(PixelsPerWord - 1));

    // Read data is on the bus the cycle after issue, i.e. while pend_q is set.
    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cur_v_d = cur_v_q;
        nxt_v_d = nxt_v_q;
        idx_d   = idx_q;
        pend_d  = issue_i;
        if (xfer) begin
            idx_d = idx_q + 1'b1;
        end
        if (vacate) begin
            cur_v_d = nxt_v_q | pend_q;
            if (nxt_v_q) begin
                cur_d   = nxt_q;
                nxt_v_d = pend_q;
                if (pend_q) begin
                    nxt_d = rdata_i;
                end
            end else if (pend_q) begin
                cur_d = rdata_i;
            end
        end else if (pend_q) begin
            if (!cur_v_q) begin
                cur_d   = rdata_i;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = rdata_i;
                nxt_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            cur_v_q <= 1'b0;
            nxt_v_q <= 1'b0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cur_v_q <= cur_v_d;
            nxt_v_q <= nxt_v_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
        end
    end

    assign shifted     = cur_q << {idx_q, 3'b000};
    assign pix_o       = shifted[DataBusSize-1 -: PixelWidth];
    assign valid_o     = cur_v_q;
    assign can_issue_o = !pend_q && (!nxt_v_q || !cur_v_q);

endmodule

// File: rtl/output_pixel_streamer.sv
// Drains the equalized frame from Output memory as an 8-bit pixel stream.
// Ports: clock, reset (sync, low), GlobalFlag, Read* memory bus, StreamDone, pix.
module output_pixel_streamer
    import output_pixel_streamer_pkg::*;
#(
    parameter logic [18:0] NumberofPixels = 19'd19200,
    parameter logic [15:0] BaseAddress    = 16'h0000,
    parameter logic [1:0]  DoneCode       = 2'b11
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             GlobalFlag,
    output logic [AddressSize-1:0] ReadAddressOutput,
    output logic                   ReadEnableOutput,
    input  logic [DataBusSize-1:0] ReadBusOutput,
    output logic                   StreamDone,
    output_pixel_streamer_if.master pix
);

    localparam logic [15:0] NumWords  = {1'b0, NumberofPixels[18:4]};
    localparam logic [18:0] LastPixel = NumberofPixels - 19'd1;

    state_e                 state_q;
    logic [AddressSize-1:0] words_q;
    logic [AddressSize-1:0] addr_q;
    logic [18:0]            pix_q;
    logic                   can_issue;
    logic                   issue;
    logic                   valid;
    logic                   xfer;

    assign issue = (state_q == ST_RUN) && can_issue && (words_q < NumWords);
    assign xfer  = valid && pix.PixelReady;

    word_prefetch_buffer u_buf (
        .clk_i       (clock),
        .rst_ni      (reset),
        .issue_i     (issue),
        .rdata_i     (ReadBusOutput),
        .ready_i     (pix.PixelReady),
        .pix_o       (pix.PixelData),
        .valid_o     (valid),
        .can_issue_o (can_issue)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            if (issue) begin
                words_q <= words_q + 16'd1;
                addr_q  <= BaseAddress + words_q;
            end
            if (xfer) begin
                pix_q <= pix_q + 19'd1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (GlobalFlag == DoneCode) begin
                        state_q <= ST_RUN;
                        words_q <= '0;
                        pix_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (xfer && (pix_q == LastPixel)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (GlobalFlag != DoneCode) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Address is live during the issue cycle and otherwise holds the last one.
    assign ReadEnableOutput  = issue;
    assign ReadAddressOutput = issue ? (BaseAddress + words_q) : addr_q;
    assign pix.PixelValid    = valid;
    assign pix.PixelLast     = valid && (pix_q == LastPixel);
    assign StreamDone        = (state_q == ST_DONE);

endmodule

// File: tb/tb_output_pixel_streamer.sv
// Testbench for output_pixel_streamer: a 32-pixel and a default-size instance.
// Cycle table, hand sequences and a frame-level reference model.
module tb_output_pixel_streamer;
    import output_pixel_streamer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   flag;
    logic         rdy;
    logic         sel;
    logic [15:0]  addr_s, addr_d;
    logic         re_s, re_d, done_s, done_d;
    logic [127:0] bus_s = '0;
    logic [127:0] bus_d = '0;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    output_pixel_streamer_if ifs ();
    output_pixel_streamer_if ifd ();
    assign ifs.PixelReady = rdy;
    assign ifd.PixelReady = rdy;

    output_pixel_streamer #(.NumberofPixels(19'd32)) dut_s (
        .clock(clk), .reset(rst_n), .GlobalFlag(flag),
        .ReadAddressOutput(addr_s), .ReadEnableOutput(re_s),
        .ReadBusOutput(bus_s), .StreamDone(done_s), .pix(ifs)
    );

    output_pixel_streamer dut_d (
        .clock(clk), .reset(rst_n), .GlobalFlag(flag),
        .ReadAddressOutput(addr_d), .ReadEnableOutput(re_d),
        .ReadBusOutput(bus_d), .StreamDone(done_d), .pix(ifd)
    );

    // Memory image: byte b of word a; equals the pixel index for a < 16.
    function automatic logic [7:0] fbyte(int a, int b);
        return 8'(a * 16 + b) ^ 8'(a >> 4);
    endfunction

    function automatic logic [127:0] word_of(logic [15:0] a);
        logic [127:0] w;
        w = '0;
        for (int b = 0; b < 16; b++) w[127-8*b -: 8] = fbyte(int'(a), b);
        return w;
    endfunction

    function automatic logic [7:0] pix_val(int k);
        return fbyte(k / 16, k % 16);
    endfunction

    always @(posedge clk) begin
        if (re_s) bus_s <= word_of(addr_s);
        if (re_d) bus_d <= word_of(addr_d);
    end

    logic        o_re, o_vld, o_last, o_done;
    logic [15:0] o_addr;
    logic [7:0]  o_data;
    assign o_re   = sel ? re_d : re_s;
    assign o_addr = sel ? addr_d : addr_s;
    assign o_vld  = sel ? ifd.PixelValid : ifs.PixelValid;
    assign o_data = sel ? ifd.PixelData : ifs.PixelData;
    assign o_last = sel ? ifd.PixelLast : ifs.PixelLast;
    assign o_done = sel ? done_d : done_s;

    function automatic logic [27:0] obs();
        return {o_re, o_addr, o_vld, (o_vld ? o_data : 8'h00), o_last, o_done};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: pixel k must be pix_val(k), reads ascend from 0,
    // stalled outputs hold, PixelLast only on the final pixel.
    task automatic run_frame(string tag, int mode, int stall, int npix);
        int reads = 0, xfers = 0, addr_err = 0, data_err = 0;
        int last_err = 0, hold_err = 0, done_cyc = -1;
        int budget = npix * 3 + 64;
        logic pv = 1'b0, pl = 1'b0, prdy = 1'b1, r;
        logic [7:0] pd = 8'h00;
        flag = 2'b11;
        for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
            if (o_done) begin
                done_cyc = cyc;
            end else begin
                if (o_re) begin
                    if (o_addr != 16'(reads)) addr_err++;
                    reads++;
                end
                if (pv && !prdy)
                    if (!o_vld || o_data != pd || o_last != pl) hold_err++;
                if (stall > 0 && cyc == stall) begin
                    check({tag, "_stall_reads"}, 64'(reads), 64'd2);
                    check({tag, "_stall_pix"}, {o_vld, o_data}, {1'b1, pix_val(0)});
                end
                case (mode)
                    0: r = 1'b1;
                    1: r = (cyc % 2 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                if (cyc < stall) r = 1'b0;
                rdy = r;
                if (o_vld && r) begin
                    if (o_data != pix_val(xfers)) data_err++;
                    if (o_last != (xfers == npix - 1)) last_err++;
                    xfers++;
                end
                pv = o_vld; pd = o_data; pl = o_last; prdy = r;
                step();
            end
        end
        check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check({tag, "_reads"}, 64'(reads), 64'(npix / 16));
        check({tag, "_xfers"}, 64'(xfers), 64'(npix));
        check({tag, "_addr_err"}, 64'(addr_err), 64'd0);
        check({tag, "_data_err"}, 64'(data_err), 64'd0);
        check({tag, "_last_err"}, 64'(last_err), 64'd0);
        check({tag, "_hold_err"}, 64'(hold_err), 64'd0);
        if (mode == 0 && stall == 0)
            check({tag, "_done_cycle"}, 64'(done_cyc), 64'(npix + 3));
    endtask

    typedef struct {
        logic [1:0]  flag;
        logic        rdy;
        logic        re;
        logic [15:0] addr;
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic        done;
    } vec_t;

    vec_t vecs [36];

    initial begin
        int nre, nlow, xf;
        logic [27:0] exp;
        rst_n = 1'b0; flag = 2'b00; rdy = 1'b1; sel = 1'b0;
        repeat (2) step();
        sel = 1'b0; check("reset_small", 64'(obs()), 64'd0);
        sel = 1'b1; check("reset_default", 64'(obs()), 64'd0);
        sel = 1'b0; rst_n = 1'b1;
        step();

        // Frame of 32 pixels with ready high; cycle 0 is the trigger cycle.
        for (int i = 0; i < 36; i++) begin
            vecs[i].flag = 2'b11;
            vecs[i].rdy  = 1'b1;
            vecs[i].re   = (i == 1) || (i == 3);
            vecs[i].addr = (i < 3) ? 16'd0 : 16'd1;
            vecs[i].vld  = (i >= 3) && (i <= 34);
            vecs[i].data = vecs[i].vld ? 8'(i - 3) : 8'h00;
            vecs[i].last = (i == 34);
            vecs[i].done = (i == 35);
        end
        for (int i = 0; i < 36; i++) begin
            flag = vecs[i].flag;
            rdy  = vecs[i].rdy;
            exp  = {vecs[i].re, vecs[i].addr, vecs[i].vld, vecs[i].data,
                    vecs[i].last, vecs[i].done};
            check($sformatf("t1_cyc%0d", i), 64'(obs()), 64'(exp));
            step();
        end

        // Flag held at done code: no retrigger, StreamDone stays high.
        nre = 0; nlow = 0;
        for (int i = 0; i < 50; i++) begin
            if (o_re) nre++;
            if (!o_done) nlow++;
            step();
        end
        check("t5_hold_reads", 64'(nre), 64'd0);
        check("t5_hold_done_low", 64'(nlow), 64'd0);

        flag = 2'b00; step();
        run_frame("t2_toggle", 1, 0, 32);
        flag = 2'b00; step();
        run_frame("t3_stall", 0, 20, 32);
        for (int k = 0; k < 3; k++) begin
            flag = 2'b00; step();
            run_frame($sformatf("rand%0d", k), 2, 0, 32);
        end

        // Default-size instance: abort after 20 transfers, then a full frame.
        sel = 1'b1; rst_n = 1'b0; flag = 2'b00; rdy = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        flag = 2'b11; xf = 0;
        for (int c = 0; c < 200 && xf < 20; c++) begin
            if (o_vld) xf++;
            step();
        end
        check("t4_pre_transfers", 64'(xf), 64'd20);
        rst_n = 1'b0; flag = 2'b00;
        step();
        check("t4_reset_outputs", 64'(obs()), 64'd0);
        rst_n = 1'b1;
        step();
        run_frame("t6_full", 0, 0, 19200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
